axis_write_sched: RTL and testbench

- Round-robin scheduler that lets NB_REQ independent requesters share one stream-to-AXI write channel.
- Each requester presents a descriptor (byte address, length in stream words).
- The block arbitrates between requesters and serialises the winning descriptor onto the channel's configuration bus as a three-word sequence.
- Sits between software/DMA-control logic and the write channel's cfg_addr/cfg_data/cfg_valid/cfg_ready port.

---
 rtl/axis_write_sched_pkg.sv | 21 ++
 rtl/axis_write_sched_if.sv | 25 ++
 rtl/axis_write_sched_rr_arbiter.sv | 31 +++
 rtl/axis_write_sched.sv | 152 +++++++++++++++
 tb/tb_axis_write_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/axis_write_sched_pkg.sv
// Shared types and constants for the round-robin cfg-bus write scheduler.
package axis_sched_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ID   = 2'd1,
    S_ADR  = 2'd2,
    S_LEN  = 2'd3
  } state_t;

  // Words per descriptor on the cfg bus: ID, address, length.
  localparam int CFG_SEQ_WORDS = 3;

  // Defaults shared with the write channel's cfg decoder.
  localparam int DEF_CFG_ID   = 1;
  localparam int DEF_CFG_ADDR = 23;
  localparam int DEF_CFG_DATA = 24;

  function automatic int ptr_inc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/axis_write_sched_if.sv
// Requester descriptor bus plus cfg bus; master = the scheduler side.
interface axis_write_sched_if #(
  parameter int NB_REQ     = 4,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) ();
  logic [NB_REQ-1:0]            req_valid;
  logic [NB_REQ-1:0]            req_ready;
  logic [NB_REQ*CFG_DWIDTH-1:0] req_address;
  logic [NB_REQ*CFG_DWIDTH-1:0] req_length;
  logic [CFG_AWIDTH-1:0]        cfg_addr;
  logic [CFG_DWIDTH-1:0]        cfg_data;
  logic                         cfg_valid;
  logic                         cfg_ready;

  modport master (
    input  req_valid, req_address, req_length, cfg_ready,
    output req_ready, cfg_addr, cfg_data, cfg_valid
  );

  modport slave (
    output req_valid, req_address, req_length, cfg_ready,
    input  req_ready, cfg_addr, cfg_data, cfg_valid
  );
endinterface

// File: rtl/axis_write_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, cyclically.
module rr_arbiter #(
  parameter int NB_REQ = 4,
  parameter int IW     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  input  logic              i_en,
  output logic [NB_REQ-1:0] o_gnt,
  output logic [IW-1:0]     o_idx,
  output logic              o_any
);
  int w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    if (i_en) begin
      for (int i = 0; i < NB_REQ; i++) begin
        w_k = (int'(i_ptr) + i) % NB_REQ;
        if (!o_any && i_req[w_k]) begin
          o_any      = 1'b1;
          o_idx      = IW'(w_k);
          o_gnt[w_k] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/axis_write_sched.sv
// Round-robin scheduler serialising requester descriptors onto a 3-word cfg bus sequence.
// Optional descriptor counter output enabled by AXIS_WRITE_SCHED_STATS_EN.
module axis_write_sched
  import axis_sched_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int CFG_ID     = DEF_CFG_ID,
  parameter int CFG_ADDR   = DEF_CFG_ADDR,
  parameter int CFG_DATA   = DEF_CFG_DATA,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  localparam int IW        = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  axis_write_sched_if.master bus,
  output logic [IW-1:0]      grant_id,
  output logic               busy
`ifdef AXIS_WRITE_SCHED_STATS_EN
  ,
  output logic [31:0]        desc_count
`endif
);
  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_ptr, w_ptr_nxt;
  logic [IW-1:0]         r_grant, w_grant_nxt;
  logic [CFG_DWIDTH-1:0] r_addr, w_addr_nxt;
  logic [CFG_DWIDTH-1:0] r_len, w_len_nxt;
  logic [CFG_AWIDTH-1:0] r_cfg_addr, w_cfg_addr_nxt;
  logic [CFG_DWIDTH-1:0] r_cfg_data, w_cfg_data_nxt;
  logic                  r_cfg_valid, w_cfg_valid_nxt;
  logic                  r_busy, w_busy_nxt;

  logic [NB_REQ-1:0]     w_gnt_oh;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_any;
  logic [CFG_DWIDTH-1:0] w_sel_addr, w_sel_len;
  logic                  w_hs;
  logic                  w_done;

  rr_arbiter #(.NB_REQ(NB_REQ), .IW(IW)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .i_en  (r_state == S_IDLE),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  assign w_sel_addr = bus.req_address[w_gnt_idx*CFG_DWIDTH +: CFG_DWIDTH];
  assign w_sel_len  = bus.req_length[w_gnt_idx*CFG_DWIDTH +: CFG_DWIDTH];
  assign w_hs       = r_cfg_valid & bus.cfg_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_addr_nxt      = r_addr;
    w_len_nxt       = r_len;
    w_cfg_addr_nxt  = r_cfg_addr;
    w_cfg_data_nxt  = r_cfg_data;
    w_cfg_valid_nxt = r_cfg_valid;
    w_busy_nxt      = r_busy;
    w_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_gnt_idx;
          w_addr_nxt  = w_sel_addr;
          w_len_nxt   = w_sel_len;
          if (w_sel_len != '0) begin
            w_state_nxt     = S_ID;
            w_cfg_addr_nxt  = CFG_AWIDTH'(CFG_ADDR);
            w_cfg_data_nxt  = CFG_DWIDTH'(CFG_ID);
            w_cfg_valid_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
          end else begin
            // Empty descriptor: acknowledge and move on without touching the channel.
            w_ptr_nxt = IW'(ptr_inc(int'(w_gnt_idx), NB_REQ));
          end
        end
      end
      S_ID: begin
        if (w_hs) begin
          w_state_nxt    = S_ADR;
          w_cfg_addr_nxt = CFG_AWIDTH'(CFG_DATA);
          w_cfg_data_nxt = r_addr;
        end
      end
      S_ADR: begin
        if (w_hs) begin
          w_state_nxt    = S_LEN;
          w_cfg_data_nxt = r_len;
        end
      end
      S_LEN: begin
        if (w_hs) begin
          w_state_nxt     = S_IDLE;
          w_cfg_addr_nxt  = '0;
          w_cfg_data_nxt  = '0;
          w_cfg_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_ptr_nxt       = IW'(ptr_inc(int'(r_grant), NB_REQ));
          w_done          = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_cfg_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_cfg_addr  <= w_cfg_addr_nxt;
      r_cfg_data  <= w_cfg_data_nxt;
      r_cfg_valid <= w_cfg_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef AXIS_WRITE_SCHED_STATS_EN
  logic [31:0] r_desc_count;

  always_ff @(posedge clk) begin
    if (rst)         r_desc_count <= '0;
    else if (w_done) r_desc_count <= r_desc_count + 32'd1;
  end

  assign desc_count = r_desc_count;
`endif

  assign bus.req_ready = w_gnt_oh;
  assign bus.cfg_addr  = r_cfg_addr;
  assign bus.cfg_data  = r_cfg_data;
  assign bus.cfg_valid = r_cfg_valid;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
endmodule

// File: tb/tb_axis_write_sched.sv
// Randomised bench for axis_write_sched against a queue-based transaction model.
module tb_axis_write_sched;
  localparam int N = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef AXIS_WRITE_SCHED_STATS_EN
  logic [31:0] desc_count;
`endif

  always #5 clk = ~clk;

  axis_write_sched_if #(.NB_REQ(N), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) bus ();

  axis_write_sched #(.NB_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef AXIS_WRITE_SCHED_STATS_EN
    ,
    .desc_count (desc_count)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Stimulus applied on the next step
  logic [N-1:0] v_valid;
  logic [31:0]  v_addr [N];
  logic [31:0]  v_len  [N];
  logic         v_rdy;
  logic         v_rst;

  // Reference model: pending cfg words, pointer, last grant, completed count
  word_t q[$];
  int    m_ptr, m_grant, m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    m_grant = 0;
    m_cnt   = 0;
  endtask

  task automatic step();
    int          pk;
    logic [N-1:0] exp_rr;
    @(negedge clk);
    rst = v_rst;
    bus.req_valid = v_valid;
    for (int i = 0; i < N; i++) begin
      bus.req_address[i*32 +: 32] = v_addr[i];
      bus.req_length[i*32 +: 32]  = v_len[i];
    end
    bus.cfg_ready = v_rdy;
    #1;
    pk     = (q.size() == 0) ? pick(v_valid, m_ptr) : -1;
    exp_rr = (pk >= 0) ? N'(1) << pk : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
    chk("cfg_valid", 64'(bus.cfg_valid), 64'(q.size() != 0));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("grant_id", 64'(grant_id), 64'(m_grant));
    if (q.size() != 0) begin
      chk("cfg_addr", 64'(bus.cfg_addr), 64'(q[0].a));
      chk("cfg_data", 64'(bus.cfg_data), 64'(q[0].d));
    end
`ifdef AXIS_WRITE_SCHED_STATS_EN
    chk("desc_count", 64'(desc_count), 64'(m_cnt));
`endif
    if (v_rst) begin
      model_reset();
    end else if (q.size() != 0) begin
      if (v_rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_ptr = (m_grant + 1) % N;
          m_cnt++;
        end
      end
    end else if (pk >= 0) begin
      m_grant = pk;
      if (v_len[pk] != 0) begin
        q.push_back('{5'd23, 32'd1});
        q.push_back('{5'd24, v_addr[pk]});
        q.push_back('{5'd24, v_len[pk]});
      end else begin
        m_ptr = (pk + 1) % N;
      end
    end
  endtask

  initial begin
    v_valid = '0;
    v_rdy   = 1'b0;
    v_rst   = 1'b0;
    for (int i = 0; i < N; i++) begin
      v_addr[i] = '0;
      v_len[i]  = '0;
    end
    rst = 1'b1;
    bus.req_valid   = '0;
    bus.req_address = '0;
    bus.req_length  = '0;
    bus.cfg_ready   = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state
    step();
    chk("rst_cfg_addr", 64'(bus.cfg_addr), 64'd0);
    chk("rst_cfg_data", 64'(bus.cfg_data), 64'd0);

    // Single request
    v_valid = 4'b0001; v_addr[0] = 32'h1000; v_len[0] = 32'd16; v_rdy = 1'b1;
    step();
    v_valid = '0;
    repeat (5) step();

    // Round-robin with everyone valid
    for (int i = 0; i < N; i++) begin
      v_addr[i] = 32'h2000 + 32'(i) * 32'h10;
      v_len[i]  = 32'(i + 1);
    end
    v_valid = '1;
    repeat (21) step();
    v_valid = '0;
    repeat (4) step();

    // Backpressure in the address word
    v_valid = 4'b0010;
    step();
    v_valid = '0;
    step();
    v_rdy = 1'b0;
    repeat (5) step();
    v_rdy = 1'b1;
    repeat (4) step();

    // Zero-length drop, then all valid to expose the advanced pointer
    v_valid = 4'b0100; v_len[2] = 32'd0;
    step();
    v_len[2] = 32'd5; v_valid = '1;
    repeat (6) step();
    v_valid = '0;
    repeat (4) step();

    // Reset while the length word is on the bus
    v_valid = 4'b1000;
    for (int k = 0; k < 10 && q.size() != 1; k++) begin
      step();
      v_valid = '0;
    end
    v_rst = 1'b1; v_rdy = 1'b0;
    step();
    v_rst = 1'b0; v_rdy = 1'b1; v_valid = 4'b0010;
    step();
    v_valid = '0;
    repeat (5) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      v_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        v_addr[i] = $urandom;
        v_len[i]  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
      end
      v_rdy = ($urandom_range(0, 9) < 7);
      v_rst = ($urandom_range(0, 399) == 0);
      step();
    end
    v_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
